// File: rtl/nand_serial_sched.sv
// Bit-serial NOT/NAND/AND/OR engine that drives one external 2-input NAND cell,
// sequencing the micro-steps for each bit and assembling the result LSB first.
module nand_serial_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             nand_x,
    output logic             nand_y,
    input  logic             nand_z
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    localparam logic [1:0] OP_NOT  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [1:0]       step_q, step_d;
    logic             t0_q, t0_d;
    logic             t1_q, t1_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             a_bit, b_bit;
    logic             last_step;

    assign a_bit = a_q[idx_q];
    assign b_bit = b_q[idx_q];

    // Gate-input selection is kept apart from next-state logic so the path
    // through the external NAND cell never forms a loop inside one process.
    always_comb begin
        nand_x    = 1'b0;
        nand_y    = 1'b0;
        last_step = 1'b0;
        if (state_q == RUN) begin
            case (op_q)
                OP_NOT: begin
                    nand_x    = a_bit;
                    nand_y    = a_bit;
                    last_step = 1'b1;
                end
                OP_NAND: begin
                    nand_x    = a_bit;
                    nand_y    = b_bit;
                    last_step = 1'b1;
                end
                OP_AND: begin
                    if (step_q == 2'd0) begin
                        nand_x = a_bit;
                        nand_y = b_bit;
                    end else begin
                        nand_x    = t0_q;
                        nand_y    = t0_q;
                        last_step = 1'b1;
                    end
                end
                default: begin
                    case (step_q)
                        2'd0: begin
                            nand_x = a_bit;
                            nand_y = a_bit;
                        end
                        2'd1: begin
                            nand_x = b_bit;
                            nand_y = b_bit;
                        end
                        default: begin
                            nand_x    = t0_q;
                            nand_y    = t1_q;
                            last_step = 1'b1;
                        end
                    endcase
                end
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        step_d   = step_q;
        t0_d     = t0_q;
        t1_d     = t1_q;
        done_d   = 1'b0;
        result_d = result_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        acc_d    = acc_q;
        if (state_q == IDLE) begin
            if (start) begin
                a_d     = a;
                b_d     = b;
                op_d    = op;
                idx_d   = '0;
                step_d  = 2'd0;
                state_d = RUN;
            end
        end else if (last_step) begin
            acc_d[idx_q] = nand_z;
            step_d       = 2'd0;
            if (idx_q == LAST_IDX) begin
                result_d = acc_d;
                done_d   = 1'b1;
                state_d  = IDLE;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end else begin
            if (step_q == 2'd0) begin
                t0_d = nand_z;
            end else begin
                t1_d = nand_z;
            end
            step_d = step_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            step_q   <= 2'd0;
            t0_q     <= 1'b0;
            t1_q     <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            step_q   <= step_d;
            t0_q     <= t0_d;
            t1_q     <= t1_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Operand latches and the accumulator are fully rewritten per operation.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        op_q  <= op_d;
        acc_q <= acc_d;
    end

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_nand_serial_sched.sv
// Bench for nand_serial_sched: vector table driven through a result scoreboard,
// plus hand sequences for restart-while-busy, back-to-back and mid-run reset.
module tb_nand_serial_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [7:0] a, b;
    logic       busy, done;
    logic [7:0] result;
    logic       nand_x, nand_y, nand_z;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
        bit         glitch;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        int         lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];
    logic xs[3], ys[3], zs[3];

    nand_serial_sched #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .nand_x (nand_x),
        .nand_y (nand_y),
        .nand_z (nand_z)
    );

    assign nand_z = ~(nand_x & nand_y);

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int lat_of(input logic [1:0] o);
        case (o)
            2'b10:   return 16;
            2'b11:   return 24;
            default: return 8;
        endcase
    endfunction

    // Called on a falling edge; start is sampled at the next rising edge (E0).
    task automatic do_op(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ex, input bit glitch);
        exp_t       e;
        int         k;
        logic [7:0] prev;
        e.res = ex;
        e.lat = lat_of(o);
        sb.push_back(e);
        prev  = result;
        op    = o;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            if (k < 3) begin
                xs[k] = nand_x;
                ys[k] = nand_y;
                zs[k] = nand_z;
            end
            check("busy_run", 32'(busy), 32'd1);
            check("result_hold", 32'(result), 32'(prev));
            if (glitch && k == 5) begin
                start = 1'b1;
                a     = 8'hFF;
                op    = 2'b00;
            end else if (glitch && k == 6) begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        check("latency", 32'(k), 32'(e.lat));
        check("result", 32'(result), 32'(e.res));
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b00, 8'hA5, 8'h00, 8'h5A, 1'b0};
        vecs[1] = '{2'b01, 8'h0F, 8'h33, 8'hFC, 1'b0};
        vecs[2] = '{2'b10, 8'hF0, 8'h3C, 8'h30, 1'b1};
        vecs[3] = '{2'b11, 8'h0F, 8'h30, 8'h3F, 1'b0};
        vecs[4] = '{2'b10, 8'hAA, 8'hFF, 8'hAA, 1'b0};
        vecs[5] = '{2'b11, 8'h81, 8'h18, 8'h99, 1'b0};
        vecs[6] = '{2'b01, 8'h0F, 8'hF0, 8'hFF, 1'b0};
        vecs[7] = '{2'b00, 8'hFF, 8'h00, 8'h00, 1'b0};

        rst_n = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 8'h00;
        b     = 8'h00;
        #3 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_xy", 32'({nand_x, nand_y}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].glitch);
            if (i == 0) begin
                check("not_bit0_xy", 32'({xs[0], ys[0]}), 32'b11);
            end
            if (i == 3) begin
                check("or_s0_xy", 32'({xs[0], ys[0]}), 32'b11);
                check("or_s1_xy", 32'({xs[1], ys[1]}), 32'b00);
                check("or_s2_xy", 32'({xs[2], ys[2]}), 32'b01);
                check("or_captures", 32'({zs[0], zs[1], zs[2]}), 32'b011);
            end
            @(negedge clk);
            check("done_pulse", 32'(done), 32'd0);
            check("idle_xy", 32'({nand_x, nand_y}), 32'd0);
        end

        // Second start lands in the done cycle and must be accepted.
        do_op(2'b01, 8'hFF, 8'hFF, 8'h00, 1'b0);
        do_op(2'b01, 8'h00, 8'h00, 8'hFF, 1'b0);
        @(negedge clk);
        check("b2b_done_pulse", 32'(done), 32'd0);

        op    = 2'b11;
        a     = 8'h0F;
        b     = 8'h30;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_xy", 32'({nand_x, nand_y}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) begin
                check("midrst_quiet", 32'({busy, done}), 32'd0);
            end
        end
        check("midrst_result_after", 32'(result), 32'd0);
        do_op(2'b00, 8'h00, 8'h00, 8'hFF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nand_serial_sched.md
Name: nand_serial_sched

Overview:
- Bit-serial scheduler that computes WIDTH-bit NOT/NAND/AND/OR results using a single shared 2-input NAND cell.
- The cell is external, a plain NAND gate primitive.
- Per bit, the block sequences the NAND micro-steps each function needs, stores intermediates, and assembles the result LSB first.
- It sits between a requester (start/done handshake) and the one physical NAND gate, trading time for gate count.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  2  function: 00 NOT a, 01 a NAND b, 10 a AND b, 11 a OR b.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored for NOT).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result valid from this cycle.
- result  output  WIDTH  registered result, held until the next done.
- nand_x  output  1  shared NAND cell input X.
- nand_y  output  1  shared NAND cell input Y.
- nand_z  input  1  shared NAND cell output, combinational from nand_x and nand_y.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: busy=0, done=0, result=0, nand_x=0, nand_y=0, state IDLE, bit index=0, micro-step=0, temps t0=t1=0.
- States: IDLE, RUN.
- IDLE:
  - nand_x and nand_y are driven 0.
  - If start=1 at a rising edge: latch a, b and op; bit index i=0; step=0; go to RUN; busy=1 from that edge.
- RUN:
  - nand_x and nand_y are combinational from the latched operands, i, step, t0 and t1.
  - At each rising edge, nand_z is captured into the destination given by the table below.
- Micro-step table (per bit i):
  - NOT: s0 x=a[i], y=a[i] -> acc[i].
  - NAND: s0 x=a[i], y=b[i] -> acc[i].
  - AND: s0 x=a[i], y=b[i] -> t0; s1 x=t0, y=t0 -> acc[i].
  - OR: s0 x=a[i], y=a[i] -> t0; s1 x=b[i], y=b[i] -> t1; s2 x=t0, y=t1 -> acc[i].
- Sequencing:
  - After the last step of bit i, step returns to 0 and i increments.
  - After the last step of bit WIDTH-1, at that same edge: result<=acc with the final bit included, done<=1, busy<=0, state returns to IDLE.
- Latency:
  - Compute cycles N = WIDTH for NOT/NAND, 2*WIDTH for AND, 3*WIDTH for OR.
  - With start sampled at edge E0, done is high for exactly the cycle between E_N and E_N+1.
  - busy is high from E0 to E_N.
  - done and busy are never high simultaneously.
- Handshake and boundaries:
  - start while busy=1 is ignored; it is not queued.
  - Changes on a, b and op during RUN have no effect.
  - start sampled at E_N+1 (the done cycle) is accepted; minimum gap is one done cycle.
  - result changes only at the done edge; acc is internal and never visible early.
  - nand_z is trusted as-is; no checking is performed.
- Reset mid-operation: immediate return to reset values. No done is generated, the partial result is discarded and result is cleared to 0.

Test Plan (WIDTH=8):
- Reset: assert rst_n=0 asynchronously mid-cycle -> busy=0, done=0, result=0x00, nand_x=nand_y=0 immediately.
- NOT: start with op=00, a=0xA5 -> busy for 8 cycles, done pulse at E8, result=0x5A; bit0 micro-step drives x=y=1.
- AND with ignored restart: op=10, a=0xF0, b=0x3C, plus a start pulse with a=0xFF at cycle 5 -> that pulse is ignored; done at E16, result=0x30.
- OR micro-steps: op=11, a=0x0F, b=0x30 -> bit0 drives (x,y)=(1,1),(0,0),(0,1) with captures 0,1,1; done at E24, result=0x3F.
- Back-to-back: op=01, a=0xFF, b=0xFF -> done at E8, result=0x00. A start with op=01, a=0x00, b=0x00 during the done cycle is accepted, giving result=0xFF at E17.
- Reset mid-operation: rst_n low at cycle 10 of an OR (a=0x0F, b=0x30), released 2 cycles later -> no done pulse, result=0x00. A following NOT with a=0x00 -> result=0xFF after 8 cycles.
